// File: rtl/gtp_block_rx_if.sv
// Lane-0 word stream into the deframer and the framed word stream out of it.
interface gtp_block_rx_if;
    logic [15:0] data_i;
    logic        kchar_i;
    logic [15:0] dout;
    logic        dvalid;
    logic        dsop;
    logic        deop;
    logic        dabort;
    logic        trig_o;

    modport master (
        output data_i, kchar_i,
        input  dout, dvalid, dsop, deop, dabort, trig_o
    );

    modport slave (
        input  data_i, kchar_i,
        output dout, dvalid, dsop, deop, dabort, trig_o
    );
endinterface

// File: rtl/gtp_block_rx.sv
// GTP lane-0 deframer: strips trigger K-chars, validates block framing,
// emits framed words with sop/eop/abort and keeps readout statistics.
module gtp_block_rx #(
    parameter logic [7:0]  IDLE_K = 8'hBC,
    parameter logic [7:0]  TRIG_K = 8'h1C,
    parameter int unsigned CNTW   = 16
) (
    input  logic            clk,
    input  logic            reset,
    gtp_block_rx_if.slave   rx,
    input  logic            cnt_clr,
    output logic [CNTW-1:0] blk_cnt,
    output logic [CNTW-1:0] trig_cnt,
    output logic [CNTW-1:0] err_cnt,
    output logic            busy
);
    localparam int unsigned REMW = 9;
    localparam logic [CNTW-1:0] CNT_MAX = '1;

    typedef enum logic {
        IDLE = 1'b0,
        BODY = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [REMW-1:0] rem_q, rem_d;
    logic [15:0]     dout_q, dout_d;
    logic            dvalid_q, dvalid_d;
    logic            dsop_q, dsop_d;
    logic            deop_q, deop_d;
    logic            dabort_q, dabort_d;
    logic            trig_q, trig_d;
    logic            busy_q, busy_d;
    logic [CNTW-1:0] blk_cnt_q, blk_cnt_d;
    logic [CNTW-1:0] trig_cnt_q, trig_cnt_d;
    logic [CNTW-1:0] err_cnt_q, err_cnt_d;

    logic            is_comma_c, is_trig_c, is_badk_c, is_hdr_c, is_dat_c;
    logic [REMW-1:0] hdr_len_c;
    logic [1:0]      err_n_c;
    logic            blk_inc_c;

    always_comb begin
        is_comma_c = rx.kchar_i && (rx.data_i[7:0] == IDLE_K);
        is_trig_c  = rx.kchar_i && (rx.data_i[7:0] == TRIG_K);
        is_badk_c  = rx.kchar_i && !is_comma_c && !is_trig_c;
        is_hdr_c   = !rx.kchar_i && rx.data_i[15];
        is_dat_c   = !rx.kchar_i && !rx.data_i[15];
        hdr_len_c  = rx.data_i[14:6];
    end

    // Framing FSM and registered output stream
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        dout_d    = dout_q;
        dvalid_d  = 1'b0;
        dsop_d    = 1'b0;
        deop_d    = 1'b0;
        dabort_d  = 1'b0;
        trig_d    = is_trig_c;
        err_n_c   = 2'd0;
        blk_inc_c = 1'b0;

        if (is_hdr_c && state_q == BODY) begin
            dabort_d = 1'b1;
            err_n_c  = 2'd1;
        end

        if (is_hdr_c) begin
            // A zero-length header is itself a framing error, even right after a truncation
            if (hdr_len_c != '0) begin
                dvalid_d = 1'b1;
                dsop_d   = 1'b1;
                dout_d   = rx.data_i;
                rem_d    = hdr_len_c;
                state_d  = BODY;
            end else begin
                err_n_c  = err_n_c + 2'd1;
                state_d  = IDLE;
            end
        end else if (state_q == IDLE) begin
            if (is_dat_c || is_badk_c) err_n_c = 2'd1;
        end else begin
            if (is_dat_c) begin
                dvalid_d = 1'b1;
                dout_d   = rx.data_i;
                rem_d    = rem_q - REMW'(1);
                if (rem_q == REMW'(1)) begin
                    deop_d    = 1'b1;
                    blk_inc_c = 1'b1;
                    state_d   = IDLE;
                end
            end else if (is_comma_c || is_badk_c) begin
                dabort_d = 1'b1;
                err_n_c  = 2'd1;
                state_d  = IDLE;
            end
        end

        busy_d = (state_d == BODY);
    end

    // Statistics; clear wins over any same-cycle increment
    always_comb begin
        blk_cnt_d  = blk_cnt_q + CNTW'(blk_inc_c);
        trig_cnt_d = trig_cnt_q + CNTW'(is_trig_c);
        if (err_cnt_q > CNT_MAX - CNTW'(err_n_c)) err_cnt_d = CNT_MAX;
        else                                     err_cnt_d = err_cnt_q + CNTW'(err_n_c);
        if (cnt_clr) begin
            blk_cnt_d  = '0;
            trig_cnt_d = '0;
            err_cnt_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            dout_q     <= '0;
            dvalid_q   <= 1'b0;
            dsop_q     <= 1'b0;
            deop_q     <= 1'b0;
            dabort_q   <= 1'b0;
            trig_q     <= 1'b0;
            busy_q     <= 1'b0;
            blk_cnt_q  <= '0;
            trig_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            dout_q     <= dout_d;
            dvalid_q   <= dvalid_d;
            dsop_q     <= dsop_d;
            deop_q     <= deop_d;
            dabort_q   <= dabort_d;
            trig_q     <= trig_d;
            busy_q     <= busy_d;
            blk_cnt_q  <= blk_cnt_d;
            trig_cnt_q <= trig_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign rx.dout   = dout_q;
    assign rx.dvalid = dvalid_q;
    assign rx.dsop   = dsop_q;
    assign rx.deop   = deop_q;
    assign rx.dabort = dabort_q;
    assign rx.trig_o = trig_q;
    assign blk_cnt   = blk_cnt_q;
    assign trig_cnt  = trig_cnt_q;
    assign err_cnt   = err_cnt_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_gtp_block_rx.sv
// Directed bench for gtp_block_rx: expected output words queued per input word.
module tb_gtp_block_rx;
    logic        clk = 1'b0;
    logic        reset;
    logic        cnt_clr;
    logic [15:0] blk_cnt, trig_cnt, err_cnt;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        dvalid;
        logic        dsop;
        logic        deop;
        logic        dabort;
        logic        trig;
        logic [15:0] dout;
    } exp_t;

    exp_t exp_q[$];

    gtp_block_rx_if rx_if ();

    gtp_block_rx dut (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx_if.slave),
        .cnt_clr  (cnt_clr),
        .blk_cnt  (blk_cnt),
        .trig_cnt (trig_cnt),
        .err_cnt  (err_cnt),
        .busy     (busy)
    );

    always #4 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one word, queue its expected output, compare one cycle later
    task automatic send(input string tag, input logic [15:0] d, input logic k,
                        input logic v, input logic sop, input logic eop,
                        input logic ab, input logic tr);
        exp_t e, got, obs;
        rx_if.data_i  = d;
        rx_if.kchar_i = k;
        e.dvalid = v; e.dsop = sop; e.deop = eop; e.dabort = ab; e.trig = tr;
        e.dout   = v ? d : 16'h0000;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        obs.dvalid = rx_if.dvalid; obs.dsop = rx_if.dsop; obs.deop = rx_if.deop;
        obs.dabort = rx_if.dabort; obs.trig = rx_if.trig_o;
        obs.dout   = rx_if.dvalid ? rx_if.dout : 16'h0000;
        checks++;
        assert (obs === got) else begin
            errors++;
            $error("FAIL %s observed v/sop/eop/ab/tr/dout=%b%b%b%b%b/%h expected=%b%b%b%b%b/%h",
                   tag, obs.dvalid, obs.dsop, obs.deop, obs.dabort, obs.trig, obs.dout,
                   got.dvalid, got.dsop, got.deop, got.dabort, got.trig, got.dout);
        end
    endtask

    task automatic clr();
        cnt_clr = 1'b1;
        send("clr", 16'h00BC, 1'b1, 0, 0, 0, 0, 0);
        cnt_clr = 1'b0;
    endtask

    initial begin
        reset = 1'b1; cnt_clr = 1'b0;
        rx_if.data_i = 16'h00BC; rx_if.kchar_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dout", rx_if.dout, 16'h0000);
        chk("rst_flags", {11'd0, rx_if.dvalid, rx_if.dsop, rx_if.deop, rx_if.dabort, rx_if.trig_o}, 16'h0000);
        chk("rst_cnts", blk_cnt | trig_cnt | err_cnt, 16'h0000);
        chk("rst_busy", {15'd0, busy}, 16'h0000);
        reset = 1'b0;

        // single-word block
        send("t1_hdr", 16'h8045, 1'b0, 1, 1, 0, 0, 0);
        chk("t1_busy", {15'd0, busy}, 16'h0001);
        send("t1_dat", 16'h0123, 1'b0, 1, 0, 1, 0, 0);
        send("t1_c0", 16'h00BC, 1'b1, 0, 0, 0, 0, 0);
        send("t1_c1", 16'h00BC, 1'b1, 0, 0, 0, 0, 0);
        chk("t1_blk", blk_cnt, 16'd1);
        chk("t1_err", err_cnt, 16'd0);
        chk("t1_busy_end", {15'd0, busy}, 16'h0000);

        // triggers interleaved within a block
        clr();
        send("t2_hdr", 16'h80C2, 1'b0, 1, 1, 0, 0, 0);
        send("t2_d1", 16'h0001, 1'b0, 1, 0, 0, 0, 0);
        send("t2_tr1", 16'h001C, 1'b1, 0, 0, 0, 0, 1);
        chk("t2_busy_trig", {15'd0, busy}, 16'h0001);
        send("t2_d2", 16'h0002, 1'b0, 1, 0, 0, 0, 0);
        send("t2_tr2", 16'h001C, 1'b1, 0, 0, 0, 0, 1);
        send("t2_d3", 16'h0003, 1'b0, 1, 0, 1, 0, 0);
        send("t2_idle", 16'h00BC, 1'b1, 0, 0, 0, 0, 0);
        chk("t2_trig", trig_cnt, 16'd2);
        chk("t2_blk", blk_cnt, 16'd1);
        chk("t2_err", err_cnt, 16'd0);

        // comma truncation
        clr();
        send("t3_hdr", 16'h8104, 1'b0, 1, 1, 0, 0, 0);
        send("t3_d1", 16'h0011, 1'b0, 1, 0, 0, 0, 0);
        send("t3_d2", 16'h0022, 1'b0, 1, 0, 0, 0, 0);
        send("t3_comma", 16'h00BC, 1'b1, 0, 0, 0, 1, 0);
        chk("t3_err", err_cnt, 16'd1);
        chk("t3_busy", {15'd0, busy}, 16'h0000);
        send("t3_after", 16'h00BC, 1'b1, 0, 0, 0, 0, 0);
        chk("t3_blk", blk_cnt, 16'd0);

        // header truncates block and starts a new one
        clr();
        send("t4_hdr", 16'h8104, 1'b0, 1, 1, 0, 0, 0);
        send("t4_d1", 16'h0011, 1'b0, 1, 0, 0, 0, 0);
        send("t4_hdr2", 16'h8047, 1'b0, 1, 1, 0, 1, 0);
        send("t4_d2", 16'h7FFF, 1'b0, 1, 0, 1, 0, 0);
        chk("t4_blk", blk_cnt, 16'd1);
        chk("t4_err", err_cnt, 16'd1);

        // IDLE errors and a trigger outside a block
        clr();
        send("t5_orphan", 16'h1234, 1'b0, 0, 0, 0, 0, 0);
        send("t5_n0", 16'h8000, 1'b0, 0, 0, 0, 0, 0);
        send("t5_badk", 16'h00F7, 1'b1, 0, 0, 0, 0, 0);
        send("t5_trig", 16'h001C, 1'b1, 0, 0, 0, 0, 1);
        chk("t5_err", err_cnt, 16'd3);
        chk("t5_trigcnt", trig_cnt, 16'd1);
        chk("t5_busy", {15'd0, busy}, 16'h0000);

        // err_cnt saturation and clear priority
        clr();
        rx_if.data_i = 16'h00F7; rx_if.kchar_i = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        chk("sat_pre", err_cnt, 16'hFFFE);
        send("sat_e1", 16'h00F7, 1'b1, 0, 0, 0, 0, 0);
        send("sat_e2", 16'h00F7, 1'b1, 0, 0, 0, 0, 0);
        send("sat_e3", 16'h00F7, 1'b1, 0, 0, 0, 0, 0);
        chk("sat_hold", err_cnt, 16'hFFFF);
        cnt_clr = 1'b1;
        send("clr_err", 16'h00F7, 1'b1, 0, 0, 0, 0, 0);
        cnt_clr = 1'b0;
        chk("clr_prio", err_cnt, 16'h0000);

        // reset mid-body, then a clean block
        send("t6_hdr", 16'h8104, 1'b0, 1, 1, 0, 0, 0);
        send("t6_d1", 16'h0055, 1'b0, 1, 0, 0, 0, 0);
        reset = 1'b1;
        send("t6_rst", 16'h0066, 1'b0, 0, 0, 0, 0, 0);
        chk("t6_dout", rx_if.dout, 16'h0000);
        chk("t6_busy", {15'd0, busy}, 16'h0000);
        reset = 1'b0;
        send("t6_hdr2", 16'h8045, 1'b0, 1, 1, 0, 0, 0);
        send("t6_d2", 16'h0123, 1'b0, 1, 0, 1, 0, 0);
        send("t6_idle", 16'h00BC, 1'b1, 0, 0, 0, 0, 0);
        chk("t6_blk", blk_cnt, 16'd1);
        chk("t6_err", err_cnt, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
